// File: rtl/alu_muldiv_seq.sv
// Iterative 32-bit unsigned MUL (low word), DIVU and REMU sequencer.
// It borrows the execute-stage ALU: ADD for shift-add multiply, SLTU/SUB for restoring divide.

`ifndef ALU_FUNCT_WIDTH
`define ALU_FUNCT_WIDTH 4
`endif
`ifndef ALU_FUNCT_ADD
`define ALU_FUNCT_ADD 4'h0
`endif
`ifndef ALU_FUNCT_SLTU
`define ALU_FUNCT_SLTU 4'h3
`endif
`ifndef ALU_FUNCT_SUB
`define ALU_FUNCT_SUB 4'h8
`endif

// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a request; ALU not owned
// MUL_ADD  | one shift-add step per cycle, 32 steps
// DIV_CMP  | shift next dividend bit into rem, compare against divisor
// DIV_SUB  | conditionally subtract divisor and set quotient bit
// DONE     | result presented until consumer accepts it
module alu_muldiv_seq #(
    parameter int N = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [1:0]                  req_op,
    input  logic [N-1:0]                req_a,
    input  logic [N-1:0]                req_b,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [N-1:0]                resp_z,
    output logic                        alu_own,
    output logic [N-1:0]                alu_x,
    output logic [N-1:0]                alu_y,
    output logic [`ALU_FUNCT_WIDTH-1:0] alu_funct,
    input  logic [N-1:0]                alu_z
);

    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REMU = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MUL_ADD = 3'd1,
        S_DIV_CMP = 3'd2,
        S_DIV_SUB = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   acc_rem, acc_rem_nxt;         // MUL accumulator / DIV partial remainder
    logic [N-1:0]   mcand, mcand_nxt;
    logic [N-1:0]   mplier_quo, mplier_quo_nxt;   // MUL multiplier / DIV dividend-then-quotient
    logic [N-1:0]   divisor, divisor_nxt;
    logic [5:0]     cnt, cnt_nxt;
    logic [1:0]     op_r, op_nxt;
    logic           hibit_r, hibit_nxt;
    logic           ge_r, ge_nxt;
    logic [N-1:0]   resp_z_nxt;
    logic [N-1:0]   shifted;
    logic           take_sub;

    assign shifted  = {acc_rem[N-2:0], mplier_quo[N-1]};
    // A remainder that overflowed out of bit 31 is always >= divisor.
    assign take_sub = ge_r | hibit_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            acc_rem    <= '0;
            mcand      <= '0;
            mplier_quo <= '0;
            divisor    <= '0;
            cnt        <= '0;
            op_r       <= '0;
            hibit_r    <= 1'b0;
            ge_r       <= 1'b0;
            resp_z     <= '0;
        end else begin
            state      <= state_nxt;
            acc_rem    <= acc_rem_nxt;
            mcand      <= mcand_nxt;
            mplier_quo <= mplier_quo_nxt;
            divisor    <= divisor_nxt;
            cnt        <= cnt_nxt;
            op_r       <= op_nxt;
            hibit_r    <= hibit_nxt;
            ge_r       <= ge_nxt;
            resp_z     <= resp_z_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        acc_rem_nxt    = acc_rem;
        mcand_nxt      = mcand;
        mplier_quo_nxt = mplier_quo;
        divisor_nxt    = divisor;
        cnt_nxt        = cnt;
        op_nxt         = op_r;
        hibit_nxt      = hibit_r;
        ge_nxt         = ge_r;
        resp_z_nxt     = resp_z;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        alu_own        = 1'b0;
        alu_x          = '0;
        alu_y          = '0;
        alu_funct      = `ALU_FUNCT_ADD;

        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_nxt  = req_op;
                    cnt_nxt = '0;
                    if (req_op == OP_DIVU || req_op == OP_REMU) begin
                        if (req_b == '0) begin
                            resp_z_nxt = (req_op == OP_DIVU) ? '1 : req_a;
                            state_nxt  = S_DONE;
                        end else begin
                            acc_rem_nxt    = '0;
                            mplier_quo_nxt = req_a;
                            divisor_nxt    = req_b;
                            state_nxt      = S_DIV_CMP;
                        end
                    end else begin
                        acc_rem_nxt    = '0;
                        mcand_nxt      = req_a;
                        mplier_quo_nxt = req_b;
                        state_nxt      = S_MUL_ADD;
                    end
                end
            end

            S_MUL_ADD: begin
                alu_own        = 1'b1;
                alu_funct      = `ALU_FUNCT_ADD;
                alu_x          = acc_rem;
                alu_y          = mplier_quo[0] ? mcand : '0;
                acc_rem_nxt    = alu_z;
                mcand_nxt      = mcand << 1;
                mplier_quo_nxt = mplier_quo >> 1;
                cnt_nxt        = cnt + 6'd1;
                if (cnt == 6'd31) begin
                    resp_z_nxt = alu_z;
                    state_nxt  = S_DONE;
                end
            end

            S_DIV_CMP: begin
                alu_own        = 1'b1;
                alu_funct      = `ALU_FUNCT_SLTU;
                alu_x          = shifted;
                alu_y          = divisor;
                acc_rem_nxt    = shifted;
                hibit_nxt      = acc_rem[N-1];
                ge_nxt         = acc_rem[N-1] | ~alu_z[0];
                mplier_quo_nxt = mplier_quo << 1;
                state_nxt      = S_DIV_SUB;
            end

            S_DIV_SUB: begin
                alu_own   = 1'b1;
                alu_funct = `ALU_FUNCT_SUB;
                alu_x     = acc_rem;
                alu_y     = divisor;
                if (take_sub) begin
                    acc_rem_nxt    = alu_z;
                    mplier_quo_nxt = {mplier_quo[N-1:1], 1'b1};
                end
                cnt_nxt = cnt + 6'd1;
                if (cnt == 6'd31) begin
                    resp_z_nxt = (op_r == OP_REMU) ? acc_rem_nxt : mplier_quo_nxt;
                    state_nxt  = S_DONE;
                end else begin
                    state_nxt = S_DIV_CMP;
                end
            end

            S_DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = S_IDLE;
            end

            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
